// File: rtl/random_pulse_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : random_pulse_monitor_if
// Brief    : Valid/ready record channel carrying one measured pulse
//            (width, interval, first tag) from the monitor to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface random_pulse_monitor_if #(
    parameter int CNT_W = 16
);
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_width;
    logic [CNT_W-1:0] rec_interval;
    logic             rec_first;

    modport master (
        output rec_valid,
        output rec_width,
        output rec_interval,
        output rec_first,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_width,
        input  rec_interval,
        input  rec_first,
        output rec_ready
    );
endinterface
`default_nettype wire

// File: rtl/random_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module   : random_pulse_monitor
// Brief    : Measures high width and rise-to-rise interval of each pulse and
//            emits one record per pulse. Optional macro RPM_MINMAX_EN adds
//            min_interval/max_interval tracking outputs.
// Revision : 1.0 - initial release
// ============================================================================
module random_pulse_monitor #(
    parameter int CNT_W   = 16,
    parameter int COUNT_W = 8
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    ena,
    input  wire                    clr,
    input  wire                    pulse_in,
    random_pulse_monitor_if.master rec,
    output logic [COUNT_W-1:0]     pulse_count,
    output logic                   overflow
`ifdef RPM_MINMAX_EN
    ,
    output logic [CNT_W-1:0]       min_interval,
    output logic [CNT_W-1:0]       max_interval
`endif
);
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] c_pc_one  = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 w_adv;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_blocked;
    logic [CNT_W-1:0]     r_ivl;
    logic [CNT_W-1:0]     r_width;
    logic [CNT_W-1:0]     w_ivl_inc;
    logic [CNT_W-1:0]     w_width_inc;
    logic [CNT_W-1:0]     r_pend_ivl;
    logic [CNT_W-1:0]     r_rec_width;
    logic [CNT_W-1:0]     r_rec_ivl;
    logic                 r_rec_valid;
    logic                 r_rec_first;
    logic                 r_first;
    logic                 r_overflow;
    logic [COUNT_W-1:0]   r_count;

    assign w_adv       = ena & ~clr;
    assign w_busy      = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_accept    = r_rec_valid & rec.rec_ready;
    assign w_blocked   = r_rec_valid & ~rec.rec_ready;
    assign w_ivl_inc   = (r_ivl == c_cnt_max) ? c_cnt_max : r_ivl + c_cnt_one;
    assign w_width_inc = (r_width == c_cnt_max) ? c_cnt_max : r_width + c_cnt_one;

    // ARM only leaves on a low level, so a pulse already high at reset/clr is skipped.
    always_comb begin
        w_state_nx = r_state;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        if (w_adv) begin
            case (r_state)
                S_ARM:   if (!pulse_in) w_state_nx = S_LOW;
                S_LOW:   if (pulse_in) begin
                             w_state_nx = S_HIGH;
                             w_rise     = 1'b1;
                         end
                S_HIGH:  if (!pulse_in) begin
                             w_state_nx = S_LOW;
                             w_fall     = 1'b1;
                         end
                default: w_state_nx = S_ARM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      r_state <= S_ARM;
        else if (clr) r_state <= S_ARM;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ivl      <= '0;
            r_width    <= '0;
            r_pend_ivl <= '0;
            r_count    <= '0;
            r_first    <= 1'b1;
        end else if (clr) begin
            r_ivl      <= '0;
            r_width    <= '0;
            r_pend_ivl <= '0;
            r_count    <= '0;
            r_first    <= 1'b1;
        end else if (w_adv) begin
            if (w_rise) begin
                r_ivl      <= '0;
                r_pend_ivl <= r_first ? '0 : w_ivl_inc;
                r_width    <= c_cnt_one;
                r_count    <= r_count + c_pc_one;
            end else begin
                if (w_busy)
                    r_ivl <= w_ivl_inc;
                if (r_state == S_HIGH && pulse_in)
                    r_width <= w_width_inc;
            end
            if (w_fall)
                r_first <= 1'b0;
        end
    end

    // A fall coinciding with an accept still loads; only a stalled record blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec_valid <= 1'b0;
            r_rec_width <= '0;
            r_rec_ivl   <= '0;
            r_rec_first <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_rec_valid <= 1'b0;
            r_rec_width <= '0;
            r_rec_ivl   <= '0;
            r_rec_first <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_fall && !w_blocked) begin
                r_rec_valid <= 1'b1;
                r_rec_width <= r_width;
                r_rec_ivl   <= r_pend_ivl;
                r_rec_first <= r_first;
            end else if (w_accept) begin
                r_rec_valid <= 1'b0;
            end
            if (w_fall && w_blocked)
                r_overflow <= 1'b1;
        end
    end

`ifdef RPM_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= c_cnt_max;
            r_max <= '0;
        end else if (clr) begin
            r_min <= c_cnt_max;
            r_max <= '0;
        end else if (w_rise && !r_first) begin
            if (w_ivl_inc < r_min) r_min <= w_ivl_inc;
            if (w_ivl_inc > r_max) r_max <= w_ivl_inc;
        end
    end

    assign min_interval = r_min;
    assign max_interval = r_max;
`endif

    assign rec.rec_valid    = r_rec_valid;
    assign rec.rec_width    = r_rec_width;
    assign rec.rec_interval = r_rec_ivl;
    assign rec.rec_first    = r_rec_first;
    assign pulse_count      = r_count;
    assign overflow         = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_random_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_pulse_monitor
// Brief    : Directed bench for random_pulse_monitor (CNT_W=16 and CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_pulse_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       clr;
    logic       pulse_in;
    logic       ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       ov_a;
    logic       ov_b;
    int         n_vec = 0;
    int         n_err = 0;

    random_pulse_monitor_if #(.CNT_W(16)) rif ();
    random_pulse_monitor_if #(.CNT_W(4))  rif_s ();
    assign rif.rec_ready   = ready;
    assign rif_s.rec_ready = ready;

`ifdef RPM_MINMAX_EN
    logic [15:0] min_a;
    logic [15:0] max_a;
    logic [3:0]  min_b;
    logic [3:0]  max_b;
`endif

    random_pulse_monitor #(.CNT_W(16), .COUNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .clr         (clr),
        .pulse_in    (pulse_in),
        .rec         (rif.master),
        .pulse_count (cnt_a),
        .overflow    (ov_a)
`ifdef RPM_MINMAX_EN
        ,
        .min_interval(min_a),
        .max_interval(max_a)
`endif
    );

    random_pulse_monitor #(.CNT_W(4), .COUNT_W(8)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .clr         (clr),
        .pulse_in    (pulse_in),
        .rec         (rif_s.master),
        .pulse_count (cnt_b),
        .overflow    (ov_b)
`ifdef RPM_MINMAX_EN
        ,
        .min_interval(min_b),
        .max_interval(max_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic v, input int w, input int iv, input logic f);
        chk({tag, ".valid"},    {31'd0, rif.rec_valid}, {31'd0, v});
        chk({tag, ".width"},    {16'd0, rif.rec_width}, w);
        chk({tag, ".interval"}, {16'd0, rif.rec_interval}, iv);
        chk({tag, ".first"},    {31'd0, rif.rec_first}, {31'd0, f});
    endtask

    task automatic drive(input logic p, input int n);
        repeat (n) begin
            pulse_in = p;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic p);
        rst      = 1'b1;
        pulse_in = p;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ena = 1'b1; clr = 1'b0; ready = 1'b1; pulse_in = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_rec("reset", 1'b0, 0, 0, 1'b0);
        chk("reset.count", {24'd0, cnt_a}, 0);
        chk("reset.overflow", {31'd0, ov_a}, 0);
        rst = 1'b0;

        // Periodic pulses: 3 high, 7 low, consumer always ready
        drive(1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3);
            drive(1'b0, 1);
            chk_rec("periodic", 1'b1, 3, (k == 0) ? 0 : 10, (k == 0));
            chk("periodic.count", {24'd0, cnt_a}, k + 1);
            drive(1'b0, 1);
            chk("periodic.accepted", {31'd0, rif.rec_valid}, 0);
            drive(1'b0, 5);
        end

        // Pulse already high when reset releases
        do_reset(1'b1);
        drive(1'b1, 4);
        chk("prehigh.count0", {24'd0, cnt_a}, 0);
        drive(1'b0, 2);
        chk("prehigh.novalid", {31'd0, rif.rec_valid}, 0);
        drive(1'b1, 5);
        chk("prehigh.count1", {24'd0, cnt_a}, 1);
        drive(1'b0, 1);
        chk_rec("prehigh", 1'b1, 5, 0, 1'b1);

        // Stalled consumer, two pulses
        do_reset(1'b0);
        ready = 1'b0;
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 1);
        chk_rec("stall.a", 1'b1, 2, 0, 1'b1);
        drive(1'b0, 3);
        chk_rec("stall.hold", 1'b1, 2, 0, 1'b1);
        drive(1'b1, 4);
        chk("stall.count", {24'd0, cnt_a}, 2);
        drive(1'b0, 1);
        chk("stall.overflow", {31'd0, ov_a}, 1);
        chk_rec("stall.kept", 1'b1, 2, 0, 1'b1);
        ready = 1'b1;
        drive(1'b0, 1);
        chk("stall.drained", {31'd0, rif.rec_valid}, 0);
        drive(1'b0, 2);
        chk("stall.noreplay", {31'd0, rif.rec_valid}, 0);
        chk("stall.count2", {24'd0, cnt_a}, 2);

        // Fall coincides with accept
        do_reset(1'b0);
        ready = 1'b0;
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 3);
        chk("coinc.pending", {31'd0, rif.rec_valid}, 1);
        drive(1'b1, 3);
        ready = 1'b1;
        drive(1'b0, 1);
        chk_rec("coinc.new", 1'b1, 3, 5, 1'b0);
        chk("coinc.overflow", {31'd0, ov_a}, 0);
        drive(1'b0, 1);
        chk("coinc.drained", {31'd0, rif.rec_valid}, 0);

        // Saturation on the 4-bit instance
        do_reset(1'b0);
        drive(1'b0, 1);
        drive(1'b1, 20);
        drive(1'b0, 1);
        chk("sat.width4", {28'd0, rif_s.rec_width}, 15);
        chk("sat.first4", {31'd0, rif_s.rec_first}, 1);
        chk_rec("sat.wide", 1'b1, 20, 0, 1'b1);
        drive(1'b0, 19);
        drive(1'b1, 1);
        drive(1'b0, 1);
        chk("sat.interval4", {28'd0, rif_s.rec_interval}, 15);
        chk("sat.width4b", {28'd0, rif_s.rec_width}, 1);
        chk_rec("sat.wideb", 1'b1, 1, 40, 1'b0);

        // Synchronous clear mid-pulse with a pending record
        do_reset(1'b0);
        ready = 1'b0;
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 2);
        chk("clr.pending", {31'd0, rif.rec_valid}, 1);
        drive(1'b1, 2);
        chk("clr.count2", {24'd0, cnt_a}, 2);
        clr = 1'b1;
        drive(1'b1, 1);
        clr = 1'b0;
        chk_rec("clr.cleared", 1'b0, 0, 0, 1'b0);
        chk("clr.count0", {24'd0, cnt_a}, 0);
        drive(1'b1, 2);
        drive(1'b0, 1);
        chk("clr.armed", {31'd0, rif.rec_valid}, 0);
        chk("clr.count_armed", {24'd0, cnt_a}, 0);
        ready = 1'b1;
        drive(1'b1, 3);
        drive(1'b0, 1);
        chk_rec("clr.next", 1'b1, 3, 0, 1'b1);
        chk("clr.count1", {24'd0, cnt_a}, 1);

        // Enable low freezes measurement; handshake still completes
        do_reset(1'b0);
        drive(1'b0, 1);
        drive(1'b1, 1);
        ena = 1'b0;
        drive(1'b0, 3);
        chk("ena.frozen", {31'd0, rif.rec_valid}, 0);
        ena = 1'b1;
        ready = 1'b0;
        drive(1'b1, 1);
        drive(1'b0, 1);
        chk_rec("ena.rec", 1'b1, 2, 0, 1'b1);
        ena = 1'b0;
        ready = 1'b1;
        drive(1'b0, 1);
        chk("ena.handshake", {31'd0, rif.rec_valid}, 0);
        ena = 1'b1;

`ifdef RPM_MINMAX_EN
        // Interval extremes: 12, 5, 30
        do_reset(1'b0);
        chk("mm.min_reset", {16'd0, min_a}, 32'h0000_FFFF);
        chk("mm.max_reset", {16'd0, max_a}, 0);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 11);
        drive(1'b1, 1);
        chk("mm.min12", {16'd0, min_a}, 12);
        chk("mm.max12", {16'd0, max_a}, 12);
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, 29);
        drive(1'b1, 1);
        drive(1'b0, 1);
        chk("mm.min", {16'd0, min_a}, 5);
        chk("mm.max", {16'd0, max_a}, 30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
